// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_ctrl
// Purpose  : Front-end dispatch controller between fetch and decode. Buffers
//            fetched instructions in a small FIFO, hands out ROB tags in
//            program order and tracks free-slot credits for the ROB, RS and
//            LSB. It releases one instruction per cycle only when every
//            structure that instruction needs has a free slot.
// Ports    : clk_in / rst_in (async, active-low) / rdy_in (global enable)
//            clear                 - flush after a mispredict
//            if_valid/if_pc/if_inst - fetch side, accepted when if_ready
//            dec_*                 - registered dispatch pulse and payload
//            rob_free/rs_free/lsb_free - one slot released this cycle
//            rob_credit            - current free ROB slots
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_ctrl #(
  parameter int ROB_WIDTH  = 4,
  parameter int ROB_SIZE   = 2 ** ROB_WIDTH,
  parameter int RS_SIZE    = 8,
  parameter int LSB_SIZE   = 8,
  parameter int FIFO_DEPTH = 4   // power of 2, at least 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 if_valid,
  input  logic [31:0]          if_pc,
  input  logic [31:0]          if_inst,
  output logic                 if_ready,
  output logic                 dec_valid,
  output logic [31:0]          dec_pc,
  output logic [31:0]          dec_inst,
  output logic [ROB_WIDTH-1:0] dec_tag,
  output logic                 dec_is_mem,
  input  logic                 rob_free,
  input  logic                 rs_free,
  input  logic                 lsb_free,
  output logic [ROB_WIDTH:0]   rob_credit
);

  localparam int FIFO_WIDTH = $clog2(FIFO_DEPTH);
  localparam int RS_CW      = $clog2(RS_SIZE + 1);
  localparam int LSB_CW     = $clog2(LSB_SIZE + 1);

  localparam logic [FIFO_WIDTH:0]   C_FIFO_FULL = (FIFO_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   C_CNT_ONE   = (FIFO_WIDTH + 1)'(1);
  localparam logic [FIFO_WIDTH-1:0] C_PTR_ONE   = FIFO_WIDTH'(1);
  localparam logic [ROB_WIDTH-1:0]  C_TAG_ONE   = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH:0]    C_ROB_FULL  = (ROB_WIDTH + 1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH:0]    C_ROB_ONE   = (ROB_WIDTH + 1)'(1);
  localparam logic [RS_CW-1:0]      C_RS_FULL   = RS_CW'(RS_SIZE);
  localparam logic [RS_CW-1:0]      C_RS_ONE    = RS_CW'(1);
  localparam logic [LSB_CW-1:0]     C_LSB_FULL  = LSB_CW'(LSB_SIZE);
  localparam logic [LSB_CW-1:0]     C_LSB_ONE   = LSB_CW'(1);
  localparam logic [6:0]            C_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]            C_OPC_STORE = 7'b0100011;

  // Fetch buffer storage (data only, no reset needed)
  logic [31:0]           pc_mem_q   [FIFO_DEPTH];
  logic [31:0]           inst_mem_q [FIFO_DEPTH];

  logic [FIFO_WIDTH-1:0] head_q, tail_q;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic [ROB_WIDTH-1:0]  tag_q;
  logic [ROB_WIDTH:0]    rob_cr_q, rob_cr_d;
  logic [RS_CW-1:0]      rs_cr_q, rs_cr_d;
  logic [LSB_CW-1:0]     lsb_cr_q, lsb_cr_d;

  logic                  dec_valid_q;
  logic [31:0]           dec_pc_q, dec_inst_q;
  logic [ROB_WIDTH-1:0]  dec_tag_q;
  logic                  dec_is_mem_q;

  logic [31:0]           head_inst;
  logic                  head_is_mem;
  logic                  has_room;
  logic                  do_push, do_pop;

  assign head_inst   = inst_mem_q[head_q];
  assign head_is_mem = (head_inst[6:0] == C_OPC_LOAD) || (head_inst[6:0] == C_OPC_STORE);
  // Anything that is not a load/store (illegal opcodes included) needs an RS slot
  assign has_room    = head_is_mem ? (lsb_cr_q != '0) : (rs_cr_q != '0);
  assign do_pop      = rdy_in & ~clear & (count_q != '0) & (rob_cr_q != '0) & has_room;

  // Uses the registered count, so a full FIFO refuses a push even while popping
  assign if_ready    = rst_in & rdy_in & ~clear & (count_q != C_FIFO_FULL);
  assign do_push     = if_valid & if_ready;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Consume and free in the same cycle cancel; a free at full is dropped
    rob_cr_d = rob_cr_q;
    if (do_pop && !rob_free)
      rob_cr_d = rob_cr_q - C_ROB_ONE;
    else if (!do_pop && rob_free && (rob_cr_q != C_ROB_FULL))
      rob_cr_d = rob_cr_q + C_ROB_ONE;

    rs_cr_d = rs_cr_q;
    if ((do_pop && !head_is_mem) && !rs_free)
      rs_cr_d = rs_cr_q - C_RS_ONE;
    else if (!(do_pop && !head_is_mem) && rs_free && (rs_cr_q != C_RS_FULL))
      rs_cr_d = rs_cr_q + C_RS_ONE;

    lsb_cr_d = lsb_cr_q;
    if ((do_pop && head_is_mem) && !lsb_free)
      lsb_cr_d = lsb_cr_q - C_LSB_ONE;
    else if (!(do_pop && head_is_mem) && lsb_free && (lsb_cr_q != C_LSB_FULL))
      lsb_cr_d = lsb_cr_q + C_LSB_ONE;
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      pc_mem_q[tail_q]   <= if_pc;
      inst_mem_q[tail_q] <= if_inst;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      rob_cr_q     <= C_ROB_FULL;
      rs_cr_q      <= C_RS_FULL;
      lsb_cr_q     <= C_LSB_FULL;
      dec_valid_q  <= 1'b0;
      dec_pc_q     <= '0;
      dec_inst_q   <= '0;
      dec_tag_q    <= '0;
      dec_is_mem_q <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        tag_q       <= '0;
        rob_cr_q    <= C_ROB_FULL;
        rs_cr_q     <= C_RS_FULL;
        lsb_cr_q    <= C_LSB_FULL;
        dec_valid_q <= 1'b0;
      end else begin
        count_q     <= count_d;
        rob_cr_q    <= rob_cr_d;
        rs_cr_q     <= rs_cr_d;
        lsb_cr_q    <= lsb_cr_d;
        dec_valid_q <= do_pop;
        if (do_push)
          tail_q <= tail_q + C_PTR_ONE;
        if (do_pop) begin
          head_q       <= head_q + C_PTR_ONE;
          tag_q        <= tag_q + C_TAG_ONE;
          dec_pc_q     <= pc_mem_q[head_q];
          dec_inst_q   <= head_inst;
          dec_tag_q    <= tag_q;
          dec_is_mem_q <= head_is_mem;
        end
      end
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_pc     = dec_pc_q;
  assign dec_inst   = dec_inst_q;
  assign dec_tag    = dec_tag_q;
  assign dec_is_mem = dec_is_mem_q;
  assign rob_credit = rob_cr_q;

endmodule
`default_nettype wire

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Front-end dispatch controller between instruction fetch and the decoder. It buffers fetched instructions in a small FIFO and allocates ROB tags in program order. It tracks free-slot credits for the ROB, RS and LSB, and releases one instruction per cycle to the decoder only when every structure that instruction needs has room. It replaces the decoder's internal free-running tag counter and its per-structure stall checks.

## Interface
- `ROB_WIDTH`, 4, tag width; `ROB_SIZE` = 2^ROB_WIDTH
- `ROB_SIZE`, 16, ROB entries; initial ROB credit
- `RS_SIZE`, 8, RS entries; initial RS credit
- `LSB_SIZE`, 8, LSB entries; initial LSB credit
- `FIFO_DEPTH`, 4, fetch-buffer entries; must be a power of 2
- `clk_in` input 1: the single clock; all state updates on its rising edge
- `rst_in` input 1: asynchronous, active-low reset
- `rdy_in` input 1: global enable; low freezes all state
- `clear` input 1: flush after a mispredict
- `if_valid` input 1: fetch presents an instruction
- `if_pc` input 32: instruction PC
- `if_inst` input 32: instruction word
- `if_ready` output 1: FIFO can accept; combinational, equals `rst_in & rdy_in & !clear & (count != FIFO_DEPTH)`
- `dec_valid` output 1: registered one-cycle dispatch pulse to the decoder
- `dec_pc` output 32: PC of the dispatched instruction
- `dec_inst` output 32: word of the dispatched instruction
- `dec_tag` output ROB_WIDTH: ROB tag of the dispatched instruction
- `dec_is_mem` output 1: dispatched opcode is 0000011 (load) or 0100011 (store)
- `rob_free` input 1: one ROB entry committed this cycle
- `rs_free` input 1: one RS entry released this cycle
- `lsb_free` input 1: one LSB entry released this cycle
- `rob_credit` output ROB_WIDTH+1: current free ROB slots, for debug and perf

## Operation
- **FIFO storage:** head pointer, tail pointer and count registers, each FIFO_WIDTH = log2(FIFO_DEPTH) wide; count is one bit wider. Pointers wrap modulo FIFO_DEPTH.
- **Push:** occurs when `if_valid & if_ready`; writes {pc, inst} at the tail.
- **Head classification:** the head is a memory op if `inst[6:0]` is 0000011 or 0100011; otherwise it is an RS op.
- **Dispatch condition:** `rdy_in & !clear & count != 0 & rob_cr != 0`, plus `lsb_cr != 0` for a memory op or `rs_cr != 0` for an RS op.
- **Dispatch actions:**
  - pop the head;
  - drive `dec_pc`, `dec_inst`, `dec_is_mem` and `dec_tag = tag` with `dec_valid = 1` for exactly one cycle;
  - increment `tag` modulo ROB_SIZE.
- **No dispatch:** `dec_valid` <= 0; the data outputs hold their last values.
- **Push and pop in the same cycle:** both allowed; count is unchanged.
- **Push when full:** refused even if a pop occurs in the same cycle, because `if_ready` uses the registered count.
- **Credit counters (rob_cr, rs_cr, lsb_cr):**
  - a dispatch consuming a slot decrements the counter;
  - the matching `*_free` input increments it;
  - both in the same cycle leave it unchanged;
  - a free received while the counter is at its size is ignored (saturate, no wrap).
  - A memory op consumes ROB + LSB; any other op consumes ROB + RS. Illegal opcodes are dispatched as RS ops; the decoder drops them.
- **`clear` (highest priority, synchronous):**
  - count, head and tail <= 0; tag <= 0; `dec_valid` <= 0;
  - credits reloaded to ROB_SIZE, RS_SIZE and LSB_SIZE;
  - `*_free` pulses in the same cycle are ignored;
  - a fetch in the same cycle is not accepted.
- **`rdy_in` low:** no register changes (including `dec_valid`, which holds); `if_ready` = 0; incoming `*_free` pulses are lost, so producers must gate their pulses with `rdy_in`.
- **Reset (`rst_in` low, asynchronous):**
  - count, head, tail and tag = 0;
  - `dec_valid` = 0; `dec_pc` = `dec_inst` = 0; `dec_tag` = 0; `dec_is_mem` = 0;
  - credits = full; `rob_credit` = ROB_SIZE;
  - `if_ready` = 0 while reset is asserted.
  - Reset mid-operation discards all buffered instructions.

## Timing
- **Push to dispatch latency:** an instruction pushed at edge k is visible at the head after k; its earliest `dec_valid` is in the cycle after edge k+1.
- **Throughput:** one push and one dispatch per cycle sustained while credits remain.
- **Free to dispatch:** a `*_free` pulse at edge k makes its credit usable for the dispatch decision evaluated in cycle k+1.
- **`rob_credit`:** reflects the registered counter; it updates on the same edge as the dispatch or free.

## Test plan
- **Basic dispatch:** after reset, push 3 ADDs at PCs 0x0, 0x4, 0x8 back-to-back -> `dec_valid` high for 3 consecutive cycles starting 2 cycles after the first push; tags 0, 1, 2; `rob_credit` 16 -> 13.
- **LSB credit stall:** set LSB_SIZE=2; push 3 LW and never pulse `lsb_free` -> exactly 2 dispatches, third held. Then pulse `lsb_free` once -> third dispatches the next cycle with tag 2.
- **Simultaneous dispatch and free:** dispatch an ADD while pulsing `rs_free` and `rob_free` -> `rs_cr` and `rob_cr` unchanged. A `rob_free` at full credit leaves `rob_credit` = 16.
- **Backpressure and tag wrap:** hold all credits at 0 and push 5 -> `if_ready` drops after 4 accepted. Then dispatch 17 instructions with frees -> tag sequence 0..15, 0.
- **Clear:** assert `clear` with 3 buffered instructions and tag = 7 -> next cycle count 0, `dec_valid` 0, tag 0, credits full. A push in the clear cycle is not accepted.
- **Reset and `rdy_in`:** drop `rst_in` asynchronously mid-dispatch -> `dec_valid` falls immediately and state matches reset values. Hold `rdy_in` low for 3 cycles -> `dec_valid`, pointers and credits are frozen.
